// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward selects,
// multi-cycle FSM states and the default register-address width.
package hazard_fwd_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MC    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_slot.sv
// Forward-select for one ID/EX source operand: EX/MEM beats a completed
// multi-cycle result, which beats MEM/WB; r0 never forwards.
module fwd_sel_slot
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic              mc_done,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    output logic [1:0]        sel
);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves sel unassigned (no latch).
        sel = FWD_RF;
        // A nonzero src matching rd implies rd is nonzero as well.
        if (src != '0) begin
            if (exmem_regwrite && exmem_rd == src) begin
                sel = FWD_EXMEM;
            end else if (mc_done && mc_rd == src) begin
                sel = FWD_MC;
            end else if (memwb_regwrite && memwb_rd == src) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard and forwarding control: per-operand forward selects,
// load-use / multi-cycle stalls, multi-cycle unit tracker and stall counter.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_SRC = 2,
    parameter int MC_LAT  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_AW-1:0]         id_rs_i,
    input  logic [REG_AW-1:0]         id_rt_i,
    input  logic                      id_mc_i,
    input  logic [NUM_SRC*REG_AW-1:0] idex_src_i,
    input  logic [REG_AW-1:0]         idex_rd_i,
    input  logic                      idex_regwrite_i,
    input  logic                      idex_memread_i,
    input  logic                      idex_mc_i,
    input  logic [REG_AW-1:0]         exmem_rd_i,
    input  logic                      exmem_regwrite_i,
    input  logic [REG_AW-1:0]         memwb_rd_i,
    input  logic                      memwb_regwrite_i,
    input  logic                      flush_i,
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic                      pc_write_o,
    output logic                      ifid_write_o,
    output logic                      bubble_o,
    output logic                      mc_busy_o,
    output logic                      mc_done_o,
    output logic [REG_AW-1:0]         mc_rd_o,
    output logic [15:0]               stall_cnt_o
);

    localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 1);

    mc_state_e         state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [REG_AW-1:0] mc_rd, mc_rd_nxt;
    logic [15:0]       stall_cnt;
    logic              mc_busy, mc_done;
    logic              load_use, mc_data, mc_struct, stall;

    // idex_regwrite_i has no role in hazard detection; it is kept for interface symmetry.
    logic unused_ok;
    assign unused_ok = idex_regwrite_i;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
        fwd_sel_slot #(.REG_AW(REG_AW)) u_slot (
            .src            (idex_src_i[k*REG_AW +: REG_AW]),
            .exmem_rd       (exmem_rd_i),
            .exmem_regwrite (exmem_regwrite_i),
            .mc_done        (mc_done),
            .mc_rd          (mc_rd),
            .memwb_rd       (memwb_rd_i),
            .memwb_regwrite (memwb_regwrite_i),
            .sel            (fwd_sel_o[2*k +: 2])
        );
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mc_rd     <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mc_rd <= mc_rd_nxt;
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_rd_nxt = mc_rd;
        if (flush_i) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nxt = ST_DONE;
                end
                default: begin
                    // Issue is accepted from DONE too, allowing back-to-back ops.
                    if (idex_mc_i) begin
                        state_nxt = ST_BUSY;
                        cnt_nxt   = CNT_INIT;
                        mc_rd_nxt = idex_rd_i;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mc_busy = (state == ST_BUSY);
        mc_done = (state == ST_DONE);
    end

    assign load_use  = idex_memread_i && idex_rd_i != '0 &&
                       (idex_rd_i == id_rs_i || idex_rd_i == id_rt_i);
    assign mc_data   = mc_busy && mc_rd != '0 && (mc_rd == id_rs_i || mc_rd == id_rt_i);
    assign mc_struct = id_mc_i && mc_busy;
    assign stall     = (load_use || mc_data || mc_struct) && !flush_i;

    assign stall_o      = stall;
    assign pc_write_o   = !stall;
    assign ifid_write_o = !stall;
    assign bubble_o     = stall;
    assign mc_busy_o    = mc_busy;
    assign mc_done_o    = mc_done;
    assign mc_rd_o      = mc_rd;
    assign stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a table of combinational vectors plus
// hand-written multi-cycle sequences for the MC tracker, flush, reset and saturation.
module tb_hazard_fwd_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] id_rs_i, id_rt_i;
    logic          id_mc_i;
    logic [AW-1:0] src0, src1;
    logic [AW-1:0] idex_rd_i;
    logic          idex_regwrite_i, idex_memread_i, idex_mc_i;
    logic [AW-1:0] exmem_rd_i;
    logic          exmem_regwrite_i;
    logic [AW-1:0] memwb_rd_i;
    logic          memwb_regwrite_i;
    logic          flush_i;
    logic [3:0]    fwd_sel_o;
    logic          stall_o, pc_write_o, ifid_write_o, bubble_o;
    logic          mc_busy_o, mc_done_o;
    logic [AW-1:0] mc_rd_o;
    logic [15:0]   stall_cnt_o;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk_i = ~clk_i;

    hazard_fwd_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .MC_LAT(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .id_rs_i          (id_rs_i),
        .id_rt_i          (id_rt_i),
        .id_mc_i          (id_mc_i),
        .idex_src_i       ({src1, src0}),
        .idex_rd_i        (idex_rd_i),
        .idex_regwrite_i  (idex_regwrite_i),
        .idex_memread_i   (idex_memread_i),
        .idex_mc_i        (idex_mc_i),
        .exmem_rd_i       (exmem_rd_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .memwb_rd_i       (memwb_rd_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .flush_i          (flush_i),
        .fwd_sel_o        (fwd_sel_o),
        .stall_o          (stall_o),
        .pc_write_o       (pc_write_o),
        .ifid_write_o     (ifid_write_o),
        .bubble_o         (bubble_o),
        .mc_busy_o        (mc_busy_o),
        .mc_done_o        (mc_done_o),
        .mc_rd_o          (mc_rd_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    typedef struct {
        logic [4:0] src0, src1, rs, rt, ex_rd;
        logic       ex_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [4:0] idex_rd;
        logic       memread;
        logic [3:0] exp_fwd;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs_i = '0; id_rt_i = '0; id_mc_i = 1'b0;
        src0 = '0; src1 = '0;
        idex_rd_i = '0; idex_regwrite_i = 1'b0; idex_memread_i = 1'b0; idex_mc_i = 1'b0;
        exmem_rd_i = '0; exmem_regwrite_i = 1'b0;
        memwb_rd_i = '0; memwb_regwrite_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    initial begin
        //          src0 src1 rs  rt  exrd exrw wbrd wbrw idrd mrd  fwd      stall
        vecs[0]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 4'b0010, 1'b0};
        vecs[1]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 4'b0001, 1'b0};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 4'b0000, 1'b0};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 4'b0000, 1'b0};
        vecs[4]  = '{5'd4, 5'd9, 5'd0, 5'd0, 5'd9, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 4'b1001, 1'b0};
        vecs[5]  = '{5'd8, 5'd8, 5'd0, 5'd0, 5'd8, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 4'b0101, 1'b0};
        vecs[6]  = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd2, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 4'b1010, 1'b0};
        vecs[7]  = '{5'd0, 5'd0, 5'd5, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'b0000, 1'b1};
        vecs[8]  = '{5'd0, 5'd0, 5'd6, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'b0000, 1'b0};
        vecs[9]  = '{5'd0, 5'd0, 5'd6, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'b0000, 1'b1};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 1'b0};
        vecs[11] = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 4'b0000, 1'b0};

        idle_inputs();
        rst_i = 1'b0;
        tick();
        check("rst_fwd", 32'(fwd_sel_o), 0);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_pcw", 32'(pc_write_o), 1);
        check("rst_ifid", 32'(ifid_write_o), 1);
        check("rst_busy", 32'(mc_busy_o), 0);
        check("rst_done", 32'(mc_done_o), 0);
        check("rst_mcrd", 32'(mc_rd_o), 0);
        check("rst_scnt", 32'(stall_cnt_o), 0);
        tick();
        rst_i = 1'b1;
        tick();
        check("post_rst_busy", 32'(mc_busy_o), 0);
        check("post_rst_stall", 32'(stall_o), 0);

        // Combinational vectors, FSM idle throughout
        for (int i = 0; i < 12; i++) begin
            src0 = vecs[i].src0; src1 = vecs[i].src1;
            id_rs_i = vecs[i].rs; id_rt_i = vecs[i].rt;
            exmem_rd_i = vecs[i].ex_rd; exmem_regwrite_i = vecs[i].ex_rw;
            memwb_rd_i = vecs[i].wb_rd; memwb_regwrite_i = vecs[i].wb_rw;
            idex_rd_i = vecs[i].idex_rd; idex_memread_i = vecs[i].memread;
            #2;
            check($sformatf("v%0d_fwd", i), 32'(fwd_sel_o), 32'(vecs[i].exp_fwd));
            check($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d_pcw", i), 32'(pc_write_o), 32'(!vecs[i].exp_stall));
            check($sformatf("v%0d_ifid", i), 32'(ifid_write_o), 32'(!vecs[i].exp_stall));
            check($sformatf("v%0d_bub", i), 32'(bubble_o), 32'(vecs[i].exp_stall));
            tick();
        end
        idle_inputs();

        // Load-use stall and counter step
        do_reset();
        idex_memread_i = 1'b1; idex_rd_i = 5'd5; id_rs_i = 5'd5;
        #2;
        check("lu_stall", 32'(stall_o), 1);
        check("lu_pcw", 32'(pc_write_o), 0);
        check("lu_bub", 32'(bubble_o), 1);
        check("lu_scnt0", 32'(stall_cnt_o), 0);
        tick();
        check("lu_scnt1", 32'(stall_cnt_o), 1);
        id_rs_i = 5'd6;
        #2;
        check("lu_clear", 32'(stall_o), 0);
        tick();
        check("lu_scnt_hold", 32'(stall_cnt_o), 1);
        idle_inputs();

        // MC issue, busy 3 cycles, single DONE with MC forward
        idex_mc_i = 1'b1; idex_rd_i = 5'd7;
        #2;
        check("mc_pre_busy", 32'(mc_busy_o), 0);
        tick();
        idex_mc_i = 1'b0; idex_rd_i = '0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mc_busy%0d", i), 32'(mc_busy_o), 1);
            check($sformatf("mc_nodone%0d", i), 32'(mc_done_o), 0);
            tick();
        end
        check("mc_done", 32'(mc_done_o), 1);
        check("mc_done_busy", 32'(mc_busy_o), 0);
        check("mc_rd", 32'(mc_rd_o), 7);
        src1 = 5'd7; memwb_rd_i = 5'd7; memwb_regwrite_i = 1'b1;
        #2;
        check("mc_fwd", 32'(fwd_sel_o[3:2]), 32'b11);
        exmem_rd_i = 5'd7; exmem_regwrite_i = 1'b1;
        #2;
        check("mc_fwd_exmem_pri", 32'(fwd_sel_o[3:2]), 32'b10);
        exmem_regwrite_i = 1'b0;
        tick();
        check("mc_done_once", 32'(mc_done_o), 0);
        check("mc_idle_fwd", 32'(fwd_sel_o[3:2]), 32'b01);
        idle_inputs();

        // MC data/structural hazards, flush mid-BUSY
        idex_mc_i = 1'b1; idex_rd_i = 5'd7;
        tick();
        idex_mc_i = 1'b0; idex_rd_i = '0;
        id_rt_i = 5'd7;
        #2;
        check("mc_data_stall", 32'(stall_o), 1);
        tick();
        id_rt_i = 5'd3; id_rs_i = 5'd2; id_mc_i = 1'b1;
        #2;
        check("mc_struct_stall", 32'(stall_o), 1);
        flush_i = 1'b1;
        #2;
        check("flush_stall", 32'(stall_o), 0);
        check("flush_pcw", 32'(pc_write_o), 1);
        tick();
        flush_i = 1'b0; id_mc_i = 1'b0;
        check("flush_idle", 32'(mc_busy_o), 0);
        check("flush_nodone", 32'(mc_done_o), 0);
        tick();
        check("flush_nodone2", 32'(mc_done_o), 0);
        idex_mc_i = 1'b1; idex_rd_i = 5'd4; flush_i = 1'b1;
        tick();
        check("flush_over_issue", 32'(mc_busy_o), 0);
        idle_inputs();

        // Back-to-back issue from DONE, then reset mid-BUSY
        idex_mc_i = 1'b1; idex_rd_i = 5'd7;
        tick();
        idex_mc_i = 1'b0;
        repeat (3) tick();
        check("b2b_done", 32'(mc_done_o), 1);
        idex_mc_i = 1'b1; idex_rd_i = 5'd9;
        tick();
        idex_mc_i = 1'b0; idex_rd_i = '0;
        check("b2b_busy", 32'(mc_busy_o), 1);
        check("b2b_nodone", 32'(mc_done_o), 0);
        check("b2b_mcrd", 32'(mc_rd_o), 9);
        id_rs_i = 5'd9;
        #2;
        check("b2b_stall", 32'(stall_o), 1);
        tick();
        rst_i = 1'b0; idex_mc_i = 1'b1; idex_rd_i = 5'd3;
        tick();
        check("rstmid_busy", 32'(mc_busy_o), 0);
        check("rstmid_scnt", 32'(stall_cnt_o), 0);
        check("rstmid_mcrd", 32'(mc_rd_o), 0);
        idle_inputs();
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rstmid_nodone%0d", i), 32'(mc_done_o), 0);
        end

        // Stall counter saturation
        do_reset();
        idex_memread_i = 1'b1; idex_rd_i = 5'd5; id_rt_i = 5'd5;
        repeat (65534) tick();
        check("sat_fffe", 32'(stall_cnt_o), 32'hFFFE);
        tick();
        check("sat_ffff", 32'(stall_cnt_o), 32'hFFFF);
        repeat (5) tick();
        check("sat_hold", 32'(stall_cnt_o), 32'hFFFF);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
